// File: rtl/button_event_decoder_if.sv
// Bundle of the button-side inputs and the event outputs of
// button_event_decoder.
//   master : the producer of btn_db/lock and the consumer of events
//            (the testbench or the upstream wrapper).
//   slave  : the decoder itself.
// There is no valid/ready handshake on this bundle. Every event output is a
// single-cycle, registered pulse that the consumer samples on the next clk edge.
// state is a debug view of the decoder FSM:
//   0 = WAIT_LOW, 1 = IDLE, 2 = PRESSED, 3 = HELD.
interface button_event_decoder_if;
  logic       btn_db;
  logic       lock;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [1:0] state;

  modport master (
    output btn_db, lock,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, state
  );

  modport slave (
    input  btn_db, lock,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, state
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns the debounced button level into single-cycle
// control events for the slot-machine controller. The events are press,
// release, long-press and auto-repeat while the button is held.
// Ports:
//   clk  - system clock; all logic runs on posedge.
//   rst  - synchronous, active-high reset.
//   bus  - button_event_decoder_if.slave, which carries:
//          btn_db, lock           (inputs)
//          press_pulse, release_pulse, long_pulse, repeat_pulse,
//          held, state            (registered outputs)
// Parameters:
//   HOLD_CYCLES   - clocks from press_pulse to long_pulse (>= 2).
//   REPEAT_CYCLES - clocks from long_pulse to the first repeat_pulse, and
//                   between successive repeat_pulses (>= 2).
module button_event_decoder #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  button_event_decoder_if.slave   bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    HELD     = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;
  logic          repeat_pulse;
  logic          held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOW;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        // Block any press until the button has been seen low. This covers a
        // button that is already high out of reset and a press that was
        // rejected because of lock.
        WAIT_LOW: begin
          if (!bus.btn_db) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        IDLE: begin
          if (bus.btn_db) begin
            cnt <= '0;
            if (!bus.lock) begin
              state       <= PRESSED;
              press_pulse <= 1'b1;
              held        <= 1'b1;
            end else begin
              state <= WAIT_LOW;
            end
          end
        end

        // Release is checked first so that it wins over a terminal count
        // on the same edge.
        PRESSED: begin
          if (!bus.btn_db) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (cnt == HOLD_TC) begin
            state      <= HELD;
            cnt        <= '0;
            long_pulse <= !bus.lock;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!bus.btn_db) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (cnt == REPEAT_TC) begin
            cnt          <= '0;
            repeat_pulse <= !bus.lock;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= WAIT_LOW;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.long_pulse    = long_pulse;
  assign bus.repeat_pulse  = repeat_pulse;
  assign bus.held          = held;
  assign bus.state         = state;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder with HOLD_CYCLES = 10 and
// REPEAT_CYCLES = 4. Each press episode is one record in a table. The
// expected output of every cycle is worked out from the event timing rules:
//   press   at offset 0
//   long    at offset HOLD
//   repeats at offset HOLD + k*REPEAT
//   release on the edge that samples the button low
// Reset-related corner cases are written out by hand.
module tb_button_event_decoder;
  localparam int H = 10;
  localparam int R = 4;
  localparam logic [1:0] ST_WAIT_LOW = 2'd0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_event_decoder_if bus();

  button_event_decoder #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Each expected word is {press, release, long, repeat, held}.
  logic [4:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int    hold;      // number of edges that sample btn_db = 1
    int    lock_on;   // first offset at which lock = 1
    int    lock_off;  // first offset at which lock returns to 0
    int    gap;       // extra low edges after the release edge
    string name;
  } press_t;

  press_t tbl[9];

  // Drive one cycle. The expected word is queued when the stimulus is
  // applied, then popped and compared at the negedge after the DUT edge.
  task automatic step(input logic b, input logic l, input logic r,
                      input logic [4:0] e, input string name);
    logic [4:0] got;
    logic [4:0] exp;
    bus.btn_db = b;
    bus.lock   = l;
    rst        = r;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got = {bus.press_pulse, bus.release_pulse, bus.long_pulse,
           bus.repeat_pulse, bus.held};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got(p,r,l,rp,h)=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic check_state(input logic [1:0] exp, input string name);
    checks++;
    if (bus.state !== exp) begin
      errors++;
      $display("FAIL %s state got=%0d expected=%0d", name, bus.state, exp);
    end
  endtask

  task automatic run_press(input press_t p);
    bit         accepted;
    logic       l;
    logic [4:0] e;
    accepted = !(p.lock_on == 0 && p.lock_off > 0);
    for (int j = 0; j <= p.hold; j++) begin
      l = (j >= p.lock_on) && (j < p.lock_off);
      e = 5'b0;
      if (accepted) begin
        if (j == p.hold) begin
          e = 5'b01000;
        end else begin
          e[0] = 1'b1;
          e[4] = (j == 0);
          e[2] = (j == H) && !l;
          e[1] = (j > H) && (((j - H) % R) == 0) && !l;
        end
      end
      step(j < p.hold, l, 1'b0, e, p.name);
    end
    for (int g = 0; g < p.gap; g++) step(1'b0, 1'b0, 1'b0, 5'b0, {p.name, "_gap"});
  endtask

  initial begin
    tbl[0] = '{30,  0,   0, 2, "long_repeat"};
    tbl[1] = '{ 9,  0,   0, 1, "short_9"};
    tbl[2] = '{10,  0,   0, 1, "release_at_tc"};
    tbl[3] = '{20,  0,  25, 0, "locked_press"};
    tbl[4] = '{12,  0,   0, 0, "after_locked"};
    tbl[5] = '{20,  5,  16, 1, "lock_mid_hold"};
    tbl[6] = '{ 8,  3, 100, 1, "lock_over_release"};
    tbl[7] = '{15, 14,  15, 2, "lock_one_repeat"};
    tbl[8] = '{ 1,  0,   0, 0, "one_cycle_press"};

    bus.btn_db = 1'b1;
    bus.lock   = 1'b0;
    rst        = 1'b1;

    // Reset while the button is high. No press may be seen until a low.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 5'b0, "reset_btn_high");
    check_state(ST_WAIT_LOW, "reset_state");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 5'b0, "high_after_reset");
    step(1'b0, 1'b0, 1'b0, 5'b0, "first_low");

    // Table-driven press episodes. Episodes with gap 0 re-press on the
    // cycle after the release.
    for (int k = 0; k < 9; k++) run_press(tbl[k]);
    step(1'b0, 1'b0, 1'b0, 5'b0, "idle_low");

    // Reset at offset 12 of a held press: long_pulse has already fired,
    // there is no release_pulse, and the press is blocked until the button
    // goes low.
    for (int j = 0; j < 12; j++)
      step(1'b1, 1'b0, 1'b0, {(j == 0), 1'b0, (j == H), 1'b0, 1'b1}, "hold_before_rst");
    step(1'b1, 1'b0, 1'b1, 5'b0, "rst_mid_hold");
    check_state(ST_WAIT_LOW, "rst_mid_state");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 5'b0, "high_after_rst");
    step(1'b0, 1'b0, 1'b0, 5'b0, "low_after_rst");
    run_press('{3, 0, 0, 2, "press_after_rst"});

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
